// File: rtl/rx_phy_v2_pkg.sv
// Shared alink definitions for the dual-rail receiver: word width, frame
// header length and the frame FSM state encoding.
package rx_phy_v2_pkg;

  localparam int RX_DATA_LEN = 32;
  localparam int HDR_LEN     = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PUSH = 1'b1
  } rx_state_e;

endpackage

// File: rtl/rx_phy_sym.sv
// Dual-rail symbol qualifier: a rail must rise and hold for FILT_LEN samples
// with the other rail quiet; both rails high for FILT_LEN samples is a stop.
module rx_phy_sym #(
  parameter int FILT_LEN = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic rx_p,
  input  logic rx_n,
  output logic bit_0,
  output logic bit_1,
  output logic stop
);

  logic [FILT_LEN:0]   hist_p, hist_n;
  logic [FILT_LEN-1:0] recent_p, recent_n;

  // hist[0] is the newest sample; hist[FILT_LEN] is the sample before the window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_p <= '0;
      hist_n <= '0;
    end else if (clr) begin
      hist_p <= '0;
      hist_n <= '0;
    end else begin
      hist_p <= {hist_p[FILT_LEN-1:0], rx_p};
      hist_n <= {hist_n[FILT_LEN-1:0], rx_n};
    end
  end

  assign recent_p = hist_p[FILT_LEN-1:0];
  assign recent_n = hist_n[FILT_LEN-1:0];

  // The edge sits at a fixed window position, so each detection lasts one cycle
  assign bit_1 = ~hist_p[FILT_LEN] & (&recent_p) & ~(|hist_n);
  assign bit_0 = ~hist_n[FILT_LEN] & (&recent_n) & ~(|hist_p);
  assign stop  = ~(hist_p[FILT_LEN] & hist_n[FILT_LEN]) & (&recent_p) & (&recent_n);

endmodule

// File: rtl/rx_phy_v2.sv
// Dual-rail serial receiver that frames the collected nonce with ID, task ID and
// timer words. Define RX_PHY_BITCNT_CHK_EN to reject stops with a wrong bit count.
module rx_phy_v2
  import rx_phy_v2_pkg::*;
#(
  parameter logic [31:0] MY_RXID     = 32'd0,
  parameter int          NONCE_WORDS = 1,
  parameter int          FILT_LEN    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_flush,
  input  logic        reg_busy,
  input  logic        task_id_vld,
  input  logic [31:0] task_id_h,
  input  logic [31:0] task_id_l,
  input  logic [31:0] timer_cnt,
  input  logic        RX_P,
  input  logic        RX_N,
  input  logic        rx_rdy,
  output logic        rx_start,
  output logic        rx_vld,
  output logic        rx_last,
  output logic [31:0] rx_dat,
  output logic        rx_drop,
  output logic        rx_err
);

  localparam int         NONCE_W   = RX_DATA_LEN * NONCE_WORDS;
  localparam int         FRAME_LEN = HDR_LEN + NONCE_WORDS;
  localparam logic [7:0] NONCE_CNT = 8'(NONCE_W);
  localparam logic [2:0] LAST_IDX  = 3'(FRAME_LEN - 1);

  rx_state_e          state, state_nxt;
  logic [2:0]         idx, idx_nxt;
  logic [7:0]         bit_cnt;
  logic               cnt_clr;
  logic               bit_0, bit_1, stop;
  logic [NONCE_W-1:0] nonce_buf, nonce_shadow;
  logic [31:0]        timer_lat, tid_h, tid_l;

  rx_phy_sym #(.FILT_LEN(FILT_LEN)) u_sym (
    .clk   (clk),
    .rst   (rst),
    .clr   (reg_flush | ~reg_busy),
    .rx_p  (RX_P),
    .rx_n  (RX_N),
    .bit_0 (bit_0),
    .bit_1 (bit_1),
    .stop  (stop)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      idx     <= '0;
      bit_cnt <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (cnt_clr)
        bit_cnt <= '0;
      else if ((bit_0 | bit_1) && bit_cnt != 8'hFF)
        bit_cnt <= bit_cnt + 8'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_clr   = 1'b0;
    rx_start  = 1'b0;
    rx_drop   = 1'b0;
    rx_err    = 1'b0;
    if (reg_flush) begin
      state_nxt = ST_IDLE;
      idx_nxt   = '0;
      cnt_clr   = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (stop) begin
            cnt_clr = 1'b1;
            if (reg_busy) begin
`ifdef RX_PHY_BITCNT_CHK_EN
              if (bit_cnt != NONCE_CNT)
                rx_err = 1'b1;
              else
`endif
              begin
                rx_start  = 1'b1;
                state_nxt = ST_PUSH;
                idx_nxt   = '0;
              end
            end
          end
        end
        ST_PUSH: begin
          // A stop here, even on the final handshake, belongs to no frame
          if (stop) begin
            rx_drop = 1'b1;
            cnt_clr = 1'b1;
          end
          if (rx_rdy) begin
            if (idx == LAST_IDX) begin
              state_nxt = ST_IDLE;
              idx_nxt   = '0;
            end else begin
              idx_nxt = idx + 3'd1;
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (bit_0 | bit_1)
      nonce_buf <= {bit_1, nonce_buf[NONCE_W-1:1]};
    if (rx_start) begin
      nonce_shadow <= nonce_buf;
      timer_lat    <= timer_cnt;
    end
    if (task_id_vld && state == ST_IDLE) begin
      tid_h <= task_id_h;
      tid_l <= task_id_l;
    end
  end

  assign rx_vld  = (state == ST_PUSH);
  assign rx_last = rx_vld && (idx == LAST_IDX);

  always_comb begin
    rx_dat = MY_RXID;
    case (idx)
      3'd1:    rx_dat = tid_h;
      3'd2:    rx_dat = tid_l;
      3'd3:    rx_dat = timer_lat;
      default: ;
    endcase
    for (int k = 0; k < NONCE_WORDS; k++)
      if (idx == 3'(HDR_LEN + k))
        rx_dat = nonce_shadow[k*RX_DATA_LEN +: RX_DATA_LEN];
  end

endmodule

// File: tb/tb_rx_phy_v2.sv
// Scoreboard bench for rx_phy_v2: two instances (one and two nonce words) share
// the serial stream; a bit-level reference model predicts frames and pulses.
module tb_rx_phy_v2;

  localparam int FILT = 2;
  localparam logic [31:0] RXID0 = 32'hA11C_0001;
  localparam logic [31:0] RXID1 = 32'hA11C_0002;
`ifdef RX_PHY_BITCNT_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, reg_flush, reg_busy, task_id_vld;
  logic [31:0] task_id_h, task_id_l, timer_cnt;
  logic        rx_p, rx_n, rx_rdy;
  logic [1:0]  rx_start, rx_vld, rx_last, rx_drop, rx_err;
  logic [31:0] dat0, dat1;

  rx_phy_v2 #(.MY_RXID(RXID0), .NONCE_WORDS(1), .FILT_LEN(FILT)) u_dut1 (
    .clk(clk), .rst(rst), .reg_flush(reg_flush), .reg_busy(reg_busy),
    .task_id_vld(task_id_vld), .task_id_h(task_id_h), .task_id_l(task_id_l),
    .timer_cnt(timer_cnt), .RX_P(rx_p), .RX_N(rx_n), .rx_rdy(rx_rdy),
    .rx_start(rx_start[0]), .rx_vld(rx_vld[0]), .rx_last(rx_last[0]),
    .rx_dat(dat0), .rx_drop(rx_drop[0]), .rx_err(rx_err[0]));

  rx_phy_v2 #(.MY_RXID(RXID1), .NONCE_WORDS(2), .FILT_LEN(FILT)) u_dut2 (
    .clk(clk), .rst(rst), .reg_flush(reg_flush), .reg_busy(reg_busy),
    .task_id_vld(task_id_vld), .task_id_h(task_id_h), .task_id_l(task_id_l),
    .timer_cnt(timer_cnt), .RX_P(rx_p), .RX_N(rx_n), .rx_rdy(rx_rdy),
    .rx_start(rx_start[1]), .rx_vld(rx_vld[1]), .rx_last(rx_last[1]),
    .rx_dat(dat1), .rx_drop(rx_drop[1]), .rx_err(rx_err[1]));

  int checks = 0;
  int passed = 0;

  // reference model state
  bit          bits_q[$];
  logic [32:0] q0[$], q1[$];
  int          mcnt[2];
  bit          in_push[2];
  logic [31:0] m_tid_h[2], m_tid_l[2];
  int          exp_start[2], exp_drop[2], exp_err[2];
  int          got_start[2], got_drop[2], got_err[2];
  bit          rdy_rand = 1'b1;
  bit          rdy_force = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [32:0] qfront(input int d);
    return (d == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpush(input int d, input logic [32:0] v);
    if (d == 0) q0.push_back(v); else q1.push_back(v);
  endtask

  task automatic qpop(input int d);
    if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
  endtask

  function automatic logic [31:0] nonce_word(input int w, input int k);
    logic [31:0] v;
    int n;
    n = bits_q.size();
    for (int j = 0; j < 32; j++) v[j] = bits_q[n - w + 32*k + j];
    return v;
  endfunction

  task automatic mon(input int d, input logic vld, input logic last, input logic [31:0] dat,
                     input logic st, input logic dr, input logic er);
    if (st) got_start[d]++;
    if (dr) got_drop[d]++;
    if (er) got_err[d]++;
    if (vld) begin
      if (qsize(d) == 0) check($sformatf("d%0d_unexpected_vld", d), 64'(dat), 64'hx);
      else begin
        check($sformatf("d%0d_word", d), 64'({last, dat}), 64'(qfront(d)));
        if (rx_rdy) qpop(d);
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      mon(0, rx_vld[0], rx_last[0], dat0, rx_start[0], rx_drop[0], rx_err[0]);
      mon(1, rx_vld[1], rx_last[1], dat1, rx_start[1], rx_drop[1], rx_err[1]);
    end
  end

  initial forever begin
    @(posedge clk);
    #2;
    rx_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input bit b);
    if (reg_busy) begin
      bits_q.push_back(b);
      if (bits_q.size() > 64) void'(bits_q.pop_front());
      for (int d = 0; d < 2; d++) if (mcnt[d] < 255) mcnt[d]++;
    end
    if (b) rx_p = 1'b1; else rx_n = 1'b1;
    repeat (FILT + 1) tick();
    rx_p = 1'b0;
    rx_n = 1'b0;
    repeat (2) tick();
  endtask

  task automatic send_bits(input logic [63:0] v, input int nb);
    for (int i = 0; i < nb; i++) send_bit(v[i]);
  endtask

  task automatic send_stop();
    timer_cnt = $urandom;
    if (reg_busy) begin
      for (int d = 0; d < 2; d++) begin
        int w;
        w = 32 * (d + 1);
        if (in_push[d]) exp_drop[d]++;
        else if (CHK && mcnt[d] != w) exp_err[d]++;
        else begin
          exp_start[d]++;
          in_push[d] = 1'b1;
          qpush(d, {1'b0, (d == 0) ? RXID0 : RXID1});
          qpush(d, {1'b0, m_tid_h[d]});
          qpush(d, {1'b0, m_tid_l[d]});
          qpush(d, {1'b0, timer_cnt});
          for (int k = 0; k <= d; k++) qpush(d, {k == d, nonce_word(w, k)});
        end
        mcnt[d] = 0;
      end
    end
    rx_p = 1'b1;
    rx_n = 1'b1;
    repeat (FILT + 1) tick();
    rx_p = 1'b0;
    rx_n = 1'b0;
    repeat (3) tick();
  endtask

  task automatic set_tid();
    task_id_h = $urandom;
    task_id_l = $urandom;
    task_id_vld = 1'b1;
    for (int d = 0; d < 2; d++)
      if (!in_push[d]) begin
        m_tid_h[d] = task_id_h;
        m_tid_l[d] = task_id_l;
      end
    tick();
    task_id_vld = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while ((q0.size() != 0 || q1.size() != 0) && t < 400) begin
      tick();
      t++;
    end
    check({tag, "_drain"}, 64'(t < 400), 64'd1);
    q0.delete();
    q1.delete();
    repeat (2) tick();
    in_push[0] = 1'b0;
    in_push[1] = 1'b0;
  endtask

  task automatic flush_now();
    reg_flush = 1'b1;
    tick();
    reg_flush = 1'b0;
    check("flush_vld_last", 64'({rx_vld, rx_last}), 64'd0);
    for (int d = 0; d < 2; d++) begin
      mcnt[d] = 0;
      in_push[d] = 1'b0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic check_counts(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_d%0d_start", tag, d), 64'(got_start[d]), 64'(exp_start[d]));
      check($sformatf("%s_d%0d_drop", tag, d), 64'(got_drop[d]), 64'(exp_drop[d]));
      check($sformatf("%s_d%0d_err", tag, d), 64'(got_err[d]), 64'(exp_err[d]));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    rst = 1'b1; reg_flush = 1'b0; reg_busy = 1'b1; task_id_vld = 1'b0;
    task_id_h = '0; task_id_l = '0; timer_cnt = '0; rx_p = 1'b0; rx_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      mcnt[d] = 0; in_push[d] = 1'b0; m_tid_h[d] = '0; m_tid_l[d] = '0;
      exp_start[d] = 0; exp_drop[d] = 0; exp_err[d] = 0;
      got_start[d] = 0; got_drop[d] = 0; got_err[d] = 0;
    end
    repeat (3) tick();
    check("rst_outs_d0", 64'({rx_vld[0], rx_last[0], rx_start[0], rx_drop[0], rx_err[0]}), 64'd0);
    check("rst_outs_d1", 64'({rx_vld[1], rx_last[1], rx_start[1], rx_drop[1], rx_err[1]}), 64'd0);
    rst = 1'b0;
    tick();

    // preload the nonce buffers, then clear the bit counters
    send_bits({$urandom, $urandom}, 64);
    flush_now();

    // directed 0xDEADBEEF frame
    set_tid();
    send_bits(64'hDEADBEEF, 32);
    send_stop();
    wait_drain("beef");
    check_counts("beef");

    // short frame (rejected only with the bit-count check)
    send_bits(64'($urandom), 31);
    send_stop();
    wait_drain("short");
    check_counts("short");

    // second stop while the frame is stalled in PUSH, plus an ignored task ID strobe
    rdy_rand = 1'b0; rdy_force = 1'b0;
    set_tid();
    send_bits(64'($urandom), 32);
    send_stop();
    set_tid();
    send_bits(64'($urandom), 5);
    send_stop();
    rdy_rand = 1'b1;
    wait_drain("drop");
    check_counts("drop");

    // one-sample glitches on each rail, then a 64-bit frame
    rx_p = 1'b1; tick(); rx_p = 1'b0; repeat (3) tick();
    rx_n = 1'b1; tick(); rx_n = 1'b0; repeat (3) tick();
    set_tid();
    send_bits({$urandom, $urandom}, 64);
    send_stop();
    wait_drain("glitch64");
    check_counts("glitch64");

    // flush while the frame sits at word 2
    rdy_rand = 1'b0; rdy_force = 1'b0;
    send_bits(64'($urandom), 32);
    send_stop();
    check("flush_push_vld", 64'(rx_vld[0]), 64'd1);
    rdy_force = 1'b1;
    tick();
    tick();
    rdy_force = 1'b0;
    flush_now();
    rdy_rand = 1'b1;
    repeat (3) tick();
    check("flush_idle_vld", 64'(rx_vld), 64'd0);
    set_tid();
    send_bits(64'($urandom), 32);
    send_stop();
    wait_drain("postflush");
    check_counts("postflush");

    // receiver disabled: line activity is ignored
    reg_busy = 1'b0;
    send_bits(64'($urandom), 12);
    send_stop();
    reg_busy = 1'b1;
    tick();
    check_counts("busy0");

    // counter saturation
    for (int i = 0; i < 5; i++) send_bits({$urandom, $urandom}, 52);
    send_stop();
    wait_drain("sat");
    check_counts("sat");

    // randomized frames of mixed lengths
    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 1) == 1) set_tid();
      case ($urandom_range(0, 3))
        0: nb = 32;
        1: nb = 64;
        2: nb = 31;
        default: nb = $urandom_range(1, 70);
      endcase
      if (nb > 64) begin
        send_bits({$urandom, $urandom}, 64);
        nb -= 64;
      end
      send_bits({$urandom, $urandom}, nb);
      send_stop();
      wait_drain("rand");
    end
    check_counts("final");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/rx_phy_v2.md
RX_PHY_V2 -- requirements
Module: rx_phy_v2

Interface
REQ-001 Parameter MY_RXID, 32'd0, constant emitted as frame word 0.
REQ-002 Parameter NONCE_WORDS, 1, 32-bit nonce words per frame (range 1..4).
REQ-003 Parameter FILT_LEN, 2, consecutive stable samples needed to qualify a symbol (range 1..4).
REQ-004 clk  input  1  single clock; all logic on posedge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 reg_flush  input  1  synchronous abort/clear.
REQ-007 reg_busy  input  1  receiver enable.
REQ-008 task_id_vld  input  1  task ID capture strobe.
REQ-009 task_id_h, task_id_l  input  32 each  task ID halves.
REQ-010 timer_cnt  input  32  free-running timer.
REQ-011 RX_P, RX_N  input  1 each  dual-rail serial line, already synchronised to clk.
REQ-012 rx_rdy  input  1  downstream ready.
REQ-013 rx_start  output  1  one-cycle pulse on frame acceptance.
REQ-014 rx_vld, rx_last  output  1 each  word valid; final word of frame.
REQ-015 rx_dat  output  32  frame word.
REQ-016 rx_drop, rx_err  output  1 each  one-cycle pulses: stop lost during push; bit-count error.

Function
REQ-017 Line idle = both rails low; sampler shall hold FILT_LEN+1 history samples per rail.
REQ-018 Symbol '1' shall be detected when P goes 0 -> 1 and stays 1 for FILT_LEN samples while N is 0 throughout; symbol '0' likewise with rails swapped.
REQ-019 Stop shall be detected when both rails are high for FILT_LEN samples, preceded by a sample that was not both-high; one detection per stop.
REQ-020 Each bit shall shift into a 32*NONCE_WORDS-bit buffer LSB-first (new bit enters MSB, buffer shifts right).
REQ-021 A 8-bit bit counter shall count bits since the last stop or flush, saturating at 255.
REQ-022 FSM states IDLE and PUSH; reset state is IDLE.
REQ-023 IDLE -> PUSH on a stop with reg_busy=1; in that cycle rx_start=1, the nonce buffer is copied to a shadow register, timer_cnt is latched, and the bit counter clears.
REQ-024 In PUSH, rx_vld=1; words in order: MY_RXID, task_id_h, task_id_l, latched timer, then shadow nonce words 0..NONCE_WORDS-1 (word 0 = bits 31:0).
REQ-025 The word index shall advance only when rx_vld && rx_rdy; rx_dat shall hold stable while rx_rdy=0.
REQ-026 rx_last=1 exactly while the index is at word 4+NONCE_WORDS-1; PUSH -> IDLE on its handshake.
REQ-027 Frame latency: first word valid the cycle after rx_start.
REQ-028 Task ID shall be captured on task_id_vld only in IDLE; a strobe during PUSH shall be ignored.
REQ-029 Bits arriving during PUSH shall keep shifting into the live buffer; a stop during PUSH shall pulse rx_drop, clear the bit counter, and not disturb the frame.
REQ-030 A stop coinciding with the final handshake shall be treated as in PUSH (dropped).
REQ-031 reg_flush=1 shall clear the sampler to idle and the bit counter, and abort PUSH to IDLE next cycle without asserting rx_last.
REQ-032 reg_busy=0 shall hold the sampler at idle, but a frame already in PUSH shall complete.

Reset
REQ-033 rst shall set state IDLE, sampler idle, counters 0, and rx_vld, rx_last, rx_start, rx_drop and rx_err to 0; data registers need no reset.

Configuration
REQ-034 Macro RX_PHY_BITCNT_CHK_EN, when defined: a stop in IDLE with bit count != 32*NONCE_WORDS shall pulse rx_err, clear the bit counter, and stay in IDLE (no rx_start).
REQ-035 When RX_PHY_BITCNT_CHK_EN is undefined, every qualified stop shall be accepted and rx_err shall be tied to 0.

Structure
REQ-036 Frame header length (4) and the FSM state encodings shall live in the shared alink define file, alongside the existing RX_DATA_LEN.
REQ-037 Dual-rail symbol detection shall be a sub-module rx_phy_sym (FILT_LEN parameter; outputs bit_0, bit_1 and stop pulses).

Verification
REQ-038 NONCE_WORDS=1, FILT_LEN=2, send 32 bits of 0xDEADBEEF LSB-first then stop, with rx_rdy=1 -> rx_start; 5 words RXID, TID_H, TID_L, timer at stop, 0xDEADBEEF; rx_last on word 4.
REQ-039 Same, but rx_rdy low for 3 cycles at word 2 -> word 2 held stable; frame completes with no loss.
REQ-040 Second stop injected mid-push -> rx_drop pulse once; the frame is unchanged.
REQ-041 With RX_PHY_BITCNT_CHK_EN, 31 bits then stop -> rx_err pulse, no rx_vld; a following 32-bit frame is accepted.
REQ-042 reg_flush at word 2 -> rx_vld low next cycle, no rx_last; the next frame is correct.
REQ-043 1-sample glitch on P with FILT_LEN=2 -> no bit counted; NONCE_WORDS=2 with a 64-bit frame -> 6 words.
